// File: rtl/somador_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encoding and sizing helpers.
package somador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of RUN cycles needed to consume a full operand.
  function automatic int unsigned calc_ndig(int unsigned width, int unsigned digit);
    return width / digit;
  endfunction

  // Digit-counter width; at least one bit even when a single digit covers the operand.
  function automatic int unsigned cnt_width(int unsigned ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/somador_serial_param_if.sv
// Start/busy/done operand and result bundle of the serial adder/subtractor.
interface somador_serial_param_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry_out, overflow
  );

endinterface

// File: rtl/somador_digito.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top bit.
module somador_digito #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  // Bitwise ripple chain from cin up to the digit carry out.
  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/somador_serial_param.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands consumed DIGIT bits per clock, LSD first.
module somador_serial_param
  import somador_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 4
) (
  input logic                    clk,
  input logic                    rst,
  somador_serial_param_if.slave  bus
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = cnt_width(NDIG);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic               carry_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_out_q;
  logic               overflow_q;

  logic               accept;
  logic               last;
  logic [DIGIT-1:0]   d_s;
  logic               d_cout;
  logic               d_cmsb;
  logic [WIDTH-1:0]   sum_shift;

  // A start is honoured only when no operation is in flight.
  assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign last   = (count_q == CNT_W'(NDIG - 1));

  somador_digito #(
    .DIGIT (DIGIT)
  ) u_digito (
    .x     (op_a_q[DIGIT-1:0]),
    .y     (op_b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s     (d_s),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  // New digit enters the result from the MSB side so the LSD ends up at bit 0.
  if (DIGIT == WIDTH) begin : g_single
    assign sum_shift = d_s;
  end else begin : g_multi
    assign sum_shift = {d_s, sum_q[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE behaves like IDLE for start so back-to-back ops have no gap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = accept ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = last ? ST_DONE : ST_RUN;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shift registers, carry, digit counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
      op_a_q      <= bus.a;
      op_b_q      <= bus.sub ? ~bus.b : bus.b;
      carry_q     <= bus.sub;
      count_q     <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      op_a_q      <= op_a_q >> DIGIT;
      op_b_q      <= op_b_q >> DIGIT;
      carry_q     <= d_cout;
      count_q     <= count_q + CNT_W'(1);
      sum_q       <= sum_shift;
      carry_out_q <= d_cout;
      if (last) begin
        overflow_q <= d_cmsb ^ d_cout;
      end
    end
  end

  // Outputs decoded from state and result registers.
  always_comb begin
    bus.busy      = (state_q == ST_RUN);
    bus.done      = (state_q == ST_DONE);
    bus.sum       = sum_q;
    bus.carry_out = carry_out_q;
    bus.overflow  = overflow_q;
  end

endmodule

// File: doc/somador_serial_param.md
Name: somador_serial_param

Overview:
Parametrised, multi-cycle adder/subtractor and the sequential successor of the team's 4-bit combinational adder.
- Processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first.
- Uses a start/busy/done handshake.
- Reports carry and signed overflow.
- Serves as the shared arithmetic unit for datapath exercises where area matters more than latency.

Parameters:
- WIDTH, 8: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4: bits processed per cycle; 1 gives a bit-serial adder, WIDTH gives a single-cycle adder.
- NDIG (localparam): WIDTH/DIGIT, the number of RUN cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  0 = A+B, 1 = A-B; latched together with the operands.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result valid from this cycle onward.
- sum  output  WIDTH  result modulo 2^WIDTH.
- carry_out  output  1  raw carry out of the MSB. For sub, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sum=0, carry_out=0, overflow=0; internal operand, carry and digit-counter registers cleared.
- States: IDLE, RUN, DONE, encoded in 2 bits.
- IDLE, start=1 at edge E0:
  - opA<=a; opB<=(sub ? ~b : b); carry<=sub; count<=0; state<=RUN.
  - sum, carry_out and overflow are cleared.
- RUN, each edge:
  - Digit adder computes opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - The DIGIT result bits are shifted into sum from the MSB side; opA and opB shift right by DIGIT.
  - carry<=digit carry out; count increments.
- Signed overflow: on the last digit, overflow <= carry into the MSB XOR carry out of the MSB. Both carries come from the digit adder.
- Completion: after edge E0+NDIG, state=DONE; busy=0, done=1; sum, carry_out and overflow are final.
- DONE:
  - After one cycle, returns to IDLE with done=0.
  - Results hold until the next accepted start.
- Timing: busy is high after edges E0..E0+NDIG-1, i.e. for exactly NDIG cycles. Latency from start edge to done is NDIG cycles.
- start while busy is ignored; a and b changes while busy are ignored.
- start=1 in DONE is accepted exactly as in IDLE. done drops and busy rises at the same edge, giving back-to-back operations with no idle cycle.
- start held high continuously produces a new operation every NDIG+1 cycles.
- DIGIT=WIDTH: NDIG=1, so the result appears one cycle after start.
- Wrap-around:
  - 0xFF+0x01 gives sum=0x00, carry_out=1.
  - For sub, carry_out=0 indicates a borrow (unsigned a<b).
- Reset asserted mid-RUN aborts the operation immediately: outputs return to reset values and no done pulse is produced.

Decomposition:
- Shared package somador_pkg:
  - 2-bit state encoding constants ST_IDLE=0, ST_RUN=1, ST_DONE=2.
  - A helper for the NDIG computation.
- One sub-module, somador_digito: combinational DIGIT-bit ripple adder.
  - Inputs: x, y, cin.
  - Outputs: s, cout, and c_msb (carry into the MSB, needed for overflow).
- The top module contains the FSM, shift registers and counter only.

Test Plan:
(WIDTH=8, DIGIT=4 unless noted; every check is made on the done cycle.)
1. Addition: start with a=0x0F, b=0x01, sub=0.
   - busy is high for exactly 2 cycles, then done pulses for 1 cycle.
   - sum=0x10, carry_out=0, overflow=0.
2. Carry and signed overflow, two operations:
   - a=0xFF, b=0x01, sub=0: sum=0x00, carry_out=1, overflow=0.
   - a=0x7F, b=0x01, sub=0: sum=0x80, carry_out=0, overflow=1.
3. Subtraction, two operations:
   - a=0x05, b=0x07, sub=1: sum=0xFE, carry_out=0 (borrow), overflow=0.
   - a=0x80, b=0x01, sub=1: sum=0x7F, carry_out=1, overflow=1.
4. Handshake:
   - Pulse start again mid-RUN with different operands: it is ignored and the first result is unchanged.
   - Assert start during the DONE cycle: a new operation begins with no idle gap, and busy rises on the same edge that done falls.
5. Reset:
   - Assert rst asynchronously between clock edges mid-RUN: all outputs go to 0 immediately and no done pulse follows.
   - After release, an operation 0x12+0x34 gives sum=0x46.
6. Exhaustive sweep at WIDTH=4, DIGIT=1 and again at DIGIT=4:
   - Cover all 16x16 operand pairs for both sub values.
   - Compare against a reference model: sum=(a±b) mod 16, with carry_out and overflow per the rules above.
   - At DIGIT=1, latency is 4 cycles; at DIGIT=4, it is 1 cycle.
